// File: rtl/park_clarke_engine_pkg.sv
// Shared constants, encodings and transform coefficients for the dq<->abc engine.
package park_clarke_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic MODE_INV = 1'b0;
   localparam logic MODE_FWD = 1'b1;

   localparam int unsigned STEP_W = 3;

   // round(frac_e7 * 1e-7 * 2^q), computed wide enough for any legal q
   function automatic logic [63:0] scale_const(input logic [63:0] frac_e7, input int unsigned q);
      logic [127:0] t;
      t = (128'(frac_e7) << q) + 128'd5000000;
      return 64'(t / 128'd10000000);
   endfunction

   function automatic logic [63:0] k_const(input int unsigned q);
      return scale_const(64'd8660254, q);
   endfunction

   function automatic logic [63:0] r_const(input int unsigned q);
      return scale_const(64'd5773503, q);
   endfunction

endpackage

// File: rtl/park_clarke_engine_if.sv
// Input/output handshake bundle of the transform engine.
interface park_clarke_engine_if #(parameter int unsigned N = 32);
   logic                in_valid;
   logic                in_ready;
   logic                mode;
   logic signed [N-1:0] x0;
   logic signed [N-1:0] x1;
   logic signed [N-1:0] x2;
   logic signed [N-1:0] ctheta;
   logic signed [N-1:0] stheta;
   logic                out_valid;
   logic                out_ready;
   logic signed [N-1:0] y0;
   logic signed [N-1:0] y1;
   logic signed [N-1:0] y2;
   logic                sat;

   modport master (output in_valid, mode, x0, x1, x2, ctheta, stheta, out_ready,
                   input  in_ready, out_valid, y0, y1, y2, sat);
   modport slave  (input  in_valid, mode, x0, x1, x2, ctheta, stheta, out_ready,
                   output in_ready, out_valid, y0, y1, y2, sat);
endinterface

// File: rtl/park_clarke_engine_q_mul_rs.sv
// Combinational signed Q-format multiply, round half up, saturate to N bits.
module q_mul_rs #(
   parameter int unsigned N = 32,
   parameter int unsigned Q = 18
) (
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   output logic signed [N-1:0] p,
   output logic                sat
);
   localparam int unsigned PW = 2 * N;
   localparam logic signed [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (Q - 1);
   localparam logic signed [PW-1:0] PMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [PW-1:0] PMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shf;

   always_comb begin
      prod = PW'(a) * PW'(b);
      shf  = (prod + RND) >>> Q;
      sat  = 1'b0;
      p    = shf[N-1:0];
      if (shf > PMAX) begin
         p   = {1'b0, {(N-1){1'b1}}};
         sat = 1'b1;
      end else if (shf < PMIN) begin
         p   = {1'b1, {(N-1){1'b0}}};
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/park_clarke_engine.sv
// Sequential dq<->abc transform: one shared Q multiplier over a 5-step schedule plus a finalize cycle.
module park_clarke_engine
   import park_clarke_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned Q = 18
) (
   input logic                 clk,
   input logic                 rst_n,
   park_clarke_engine_if.slave bus
);
   localparam int unsigned W = N + 2;
   localparam logic signed [N-1:0] KC   = signed'(N'(k_const(Q)));
   localparam logic signed [N-1:0] RC   = signed'(N'(r_const(Q)));
   localparam logic signed [W-1:0] WMAX = {3'b000, {(N-1){1'b1}}};
   localparam logic signed [W-1:0] WMIN = {3'b111, {(N-1){1'b0}}};

   function automatic logic signed [W-1:0] ext(input logic signed [N-1:0] v);
      return {{2{v[N-1]}}, v};
   endfunction

   function automatic logic signed [N-1:0] clip(input logic signed [W-1:0] v, output logic ov);
      ov = 1'b1;
      if (v > WMAX)      return {1'b0, {(N-1){1'b1}}};
      else if (v < WMIN) return {1'b1, {(N-1){1'b0}}};
      ov = 1'b0;
      return v[N-1:0];
   endfunction

   state_t              state;
   logic [STEP_W-1:0]   step;
   logic                mode_r;
   logic signed [N-1:0] x0_r, x1_r, c_r, s_r;
   logic signed [N-1:0] p0, p1, p2, p3, p4, alpha_r;
   logic signed [N-1:0] y0_r, y1_r, y2_r;
   logic                sat_r, in_ready_r, out_valid_r;

   logic signed [N-1:0] ma, mb, mp;
   logic                msat;
   logic signed [N-1:0] two_ib, t_sum, alpha_c, beta_c, half;
   logic signed [N-1:0] yi1, yi2, yf0, yf1;
   logic                ov_2ib, ov_t, ov_a, ov_b, ov_i1, ov_i2, ov_f0, ov_f1;
   logic                ev;

   q_mul_rs #(.N(N), .Q(Q)) u_mul (.a(ma), .b(mb), .p(mp), .sat(msat));

   // Adders, operand schedule and per-step saturation events
   always_comb begin
      two_ib  = clip(ext(x1_r) <<< 1, ov_2ib);
      t_sum   = clip(ext(x0_r) + ext(two_ib), ov_t);
      alpha_c = clip(ext(p0) - ext(p1), ov_a);
      beta_c  = clip(ext(p2) + ext(p3), ov_b);
      half    = alpha_r >>> 1;
      yi1     = clip(ext(p4) - ext(half), ov_i1);
      yi2     = clip(-ext(half) - ext(p4), ov_i2);
      yf0     = clip(ext(p1) + ext(p2), ov_f0);
      yf1     = clip(ext(p4) - ext(p3), ov_f1);
      ma      = '0;
      mb      = '0;
      ev      = 1'b0;
      if (mode_r == MODE_FWD) begin
         case (step)
            3'd0:    begin ma = RC;  mb = t_sum; ev = msat | ov_2ib | ov_t; end
            3'd1:    begin ma = c_r; mb = x0_r;  ev = msat; end
            3'd2:    begin ma = s_r; mb = p0;    ev = msat; end
            3'd3:    begin ma = s_r; mb = x0_r;  ev = msat; end
            3'd4:    begin ma = c_r; mb = p0;    ev = msat; end
            default: ev = ov_f0 | ov_f1;
         endcase
      end else begin
         case (step)
            3'd0:    begin ma = c_r; mb = x0_r;   ev = msat; end
            3'd1:    begin ma = s_r; mb = x1_r;   ev = msat; end
            3'd2:    begin ma = s_r; mb = x0_r;   ev = msat | ov_a; end
            3'd3:    begin ma = c_r; mb = x1_r;   ev = msat; end
            3'd4:    begin ma = KC;  mb = beta_c; ev = msat | ov_b; end
            default: ev = ov_i1 | ov_i2;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         step        <= '0;
         mode_r      <= MODE_INV;
         x0_r        <= '0;
         x1_r        <= '0;
         c_r         <= '0;
         s_r         <= '0;
         p0          <= '0;
         p1          <= '0;
         p2          <= '0;
         p3          <= '0;
         p4          <= '0;
         alpha_r     <= '0;
         y0_r        <= '0;
         y1_r        <= '0;
         y2_r        <= '0;
         sat_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               mode_r     <= bus.mode;
               x0_r       <= bus.x0;
               x1_r       <= bus.x1;
               c_r        <= bus.ctheta;
               s_r        <= bus.stheta;
               sat_r      <= 1'b0;
               step       <= '0;
               in_ready_r <= 1'b0;
               state      <= MUL;
            end
            MUL: begin
               sat_r <= sat_r | ev;
               step  <= step + 3'd1;
               case (step)
                  3'd0: p0 <= mp;
                  3'd1: p1 <= mp;
                  3'd2: begin
                     p2 <= mp;
                     if (mode_r == MODE_INV) alpha_r <= alpha_c;
                  end
                  3'd3: p3 <= mp;
                  3'd4: p4 <= mp;
                  default: begin
                     // Finalize: results come only from registered products
                     if (mode_r == MODE_INV) begin
                        y0_r <= alpha_r;
                        y1_r <= yi1;
                        y2_r <= yi2;
                     end else begin
                        y0_r <= yf0;
                        y1_r <= yf1;
                        y2_r <= '0;
                     end
                     step        <= '0;
                     out_valid_r <= 1'b1;
                     state       <= OUT;
                  end
               endcase
            end
            OUT: if (bus.out_ready) begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.y0        = y0_r;
   assign bus.y1        = y1_r;
   assign bus.y2        = y2_r;
   assign bus.sat       = sat_r;

endmodule

// File: tb/tb_park_clarke_engine.sv
// Directed bench for park_clarke_engine: hand-computed vectors, latency, backpressure, async reset.
module tb_park_clarke_engine;
   import park_clarke_pkg::*;

   localparam int unsigned N = 32;
   localparam int unsigned Q = 18;
   localparam int ONE  = 262144;
   localparam int MAXI = 2147483647;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ntests = 0;
   int   nfail = 0;

   park_clarke_engine_if #(.N(N)) bus ();
   park_clarke_engine #(.N(N), .Q(Q)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start(input string tag, input logic m, input int a, input int b,
                        input int c, input int s);
      @(negedge clk);
      chk({tag, "/in_ready"}, longint'(bus.in_ready), 1);
      bus.mode     = m;
      bus.x0       = N'(a);
      bus.x1       = N'(b);
      bus.x2       = N'(32'h5A5A5A5A);
      bus.ctheta   = N'(c);
      bus.stheta   = N'(s);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!bus.out_valid && n < 20);
      chk({tag, "/latency"}, longint'(n), 6);
   endtask

   task automatic check_y(input string tag, input longint e0, input longint e1,
                          input longint e2, input logic es);
      chk({tag, "/y0"}, longint'(bus.y0), e0);
      chk({tag, "/y1"}, longint'(bus.y1), e1);
      chk({tag, "/y2"}, longint'(bus.y2), e2);
      chk({tag, "/sat"}, longint'(bus.sat), longint'(es));
   endtask

   task automatic handoff(input string tag);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk({tag, "/out_valid_clr"}, longint'(bus.out_valid), 0);
      chk({tag, "/in_ready_ret"}, longint'(bus.in_ready), 1);
   endtask

   task automatic txn(input string tag, input logic m, input int a, input int b,
                      input int c, input int s, input longint e0, input longint e1,
                      input longint e2, input logic es);
      start(tag, m, a, b, c, s);
      wait_out(tag);
      check_y(tag, e0, e1, e2, es);
      handoff(tag);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.mode      = MODE_INV;
      bus.x0        = '0;
      bus.x1        = '0;
      bus.x2        = '0;
      bus.ctheta    = '0;
      bus.stheta    = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset/out_valid", longint'(bus.out_valid), 0);
      chk("reset/in_ready", longint'(bus.in_ready), 1);
      check_y("reset", 0, 0, 0, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      txn("inv0", MODE_INV, ONE, 0, ONE, 0, ONE, -131072, -131072, 1'b0);
      txn("inv90", MODE_INV, 0, ONE, 0, ONE, -ONE, 131072, 131072, 1'b0);
      txn("invK", MODE_INV, ONE, 0, 0, ONE, 0, 227023, -227023, 1'b0);
      txn("fwd0", MODE_FWD, ONE, -131072, ONE, 0, ONE, 0, 0, 1'b0);
      txn("fwdR", MODE_FWD, ONE, 0, 0, ONE, 151349, -ONE, 0, 1'b0);
      txn("sat_add", MODE_INV, MAXI, MAXI, ONE, ONE, 0, 1859772415, -1859772415, 1'b1);
      txn("clean", MODE_INV, ONE, 0, ONE, 0, ONE, -131072, -131072, 1'b0);
      txn("sat_mul", MODE_INV, MAXI, 0, MAXI, 0, MAXI, -1073741823, -1073741823, 1'b1);
      txn("sat_2ib", MODE_FWD, 0, MAXI, ONE, 0, 0, 1239851007, 0, 1'b1);

      // Backpressure: outputs frozen and new offers ignored while out_ready is low
      start("bp", MODE_INV, 0, ONE, 0, ONE);
      wait_out("bp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = (i % 2 == 0);
         bus.x0       = N'($urandom);
         bus.mode     = (i % 3 == 0) ? MODE_FWD : MODE_INV;
         @(posedge clk);
         #1;
         check_y("bp_hold", -ONE, 131072, 131072, 1'b0);
         chk("bp_hold/out_valid", longint'(bus.out_valid), 1);
         chk("bp_hold/in_ready", longint'(bus.in_ready), 0);
      end
      handoff("bp");
      @(posedge clk);
      #1 chk("bp/single_handshake", longint'(bus.out_valid), 0);

      // Asynchronous reset while the multiplier is on step 2
      start("rst", MODE_FWD, ONE, -131072, ONE, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst/out_valid", longint'(bus.out_valid), 0);
      check_y("rst", 0, 0, 0, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst/in_ready", longint'(bus.in_ready), 1);
      txn("post_rst", MODE_INV, ONE, 0, 0, ONE, 0, 227023, -227023, 1'b0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
